// File: rtl/permutation_ctrl.sv
// Sequencing controller for the 25-bit line-permutation datapath: per line it
// reads, loads, permutes and writes back, then pulses done after LINES lines.
module permutation_ctrl #(
    parameter int unsigned LINES  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_valid,
    input  logic              wr_ready,
    output logic              rd_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic              reg_clr,
    output logic              reg_ld,
    output logic              perm_sel,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        WAIT_RD,
        PERM,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINES - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic              wait_q;
    logic              perm_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR: begin
                cnt_nx   = '0;
                state_nx = READ;
            end
            READ:    state_nx = WAIT_RD;
            WAIT_RD: if (rd_valid) state_nx = PERM;
            PERM:    state_nx = WRITE;
            WRITE: begin
                if (wr_ready) begin
                    // Counter returns to 0 on the final accept so addr reads 0 in DONE.
                    if (cnt == LAST) begin
                        cnt_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = cnt + ADDR_W'(1);
                        state_nx = READ;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they decode the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            reg_clr <= 1'b0;
            wait_q  <= 1'b0;
            perm_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rd_en   <= (state_nx == READ);
            wr_en   <= (state_nx == WRITE);
            reg_clr <= (state_nx == CLEAR);
            wait_q  <= (state_nx == WAIT_RD);
            perm_q  <= (state_nx == PERM);
            busy    <= (state_nx == CLEAR) || (state_nx == READ) || (state_nx == WAIT_RD) ||
                       (state_nx == PERM)  || (state_nx == WRITE);
            done    <= (state_nx == DONE);
        end
    end

    assign reg_ld   = perm_q | (wait_q & rd_valid);
    assign perm_sel = perm_q;
    assign addr     = cnt;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Randomized self-checking bench for permutation_ctrl: a responder models the
// stores, and expected timing/order comes from per-line latency arithmetic.
module tb_permutation_ctrl;

    localparam int unsigned LINES  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rd_valid;
    logic              wr_ready;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic              reg_clr;
    logic              reg_ld;
    logic              perm_sel;
    logic              busy;
    logic              done;

    permutation_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid), .wr_ready(wr_ready),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .reg_clr(reg_clr), .reg_ld(reg_ld),
        .perm_sel(perm_sel), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int rd_lat[LINES];
    int wr_lat[LINES];
    int rd_q[$];
    int wr_q[$];

    int obs_start, obs_done, obs_clr, obs_busy, obs_ld_bad, obs_excl;
    int obs_wr_unstable, obs_idle_addr, obs_done_cnt;
    bit obs_aborted;
    logic [12:0] obs_snap;

    function automatic int exp_latency();
        int s = 2 + 4 * LINES;
        for (int i = 0; i < LINES; i++) s += rd_lat[i] + wr_lat[i];
        return s;
    endfunction

    function automatic int seq_errs(input bit use_wr);
        int e = 0;
        int n = use_wr ? wr_q.size() : rd_q.size();
        if (n != LINES) e++;
        for (int i = 0; i < n; i++)
            if ((use_wr ? wr_q[i] : rd_q[i]) != i) e++;
        return e;
    endfunction

    task automatic clear_lat();
        for (int i = 0; i < LINES; i++) begin
            rd_lat[i] = 0;
            wr_lat[i] = 0;
        end
    endtask

    // Drives one run through the store responder and records what the DUT did.
    task automatic run_pass(input bit hold_start, input bit spurious, input int abort_line);
        bit armed = 0;
        bit resp = 0;
        bit resp_prev = 0;
        bit wr_act = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        int wr_addr0 = 0;
        int limit = exp_latency() + 30;
        obs_done = 0; obs_clr = 0; obs_busy = 0; obs_ld_bad = 0; obs_excl = 0;
        obs_wr_unstable = 0; obs_idle_addr = 0; obs_done_cnt = 0; obs_aborted = 0;
        obs_snap = '1;
        rd_q.delete();
        wr_q.delete();
        @(posedge clk); #1; cyc++;
        start = 1'b1; rd_valid = 1'b0; wr_ready = 1'b1;
        obs_start = cyc;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1; cyc++;
            if (abort_line >= 0 && wr_en && int'(addr) == abort_line) begin
                rst = 1'b1;
                #1;
                obs_snap = {rd_en, wr_en, addr, reg_clr, reg_ld, perm_sel, busy, done};
                obs_aborted = 1;
                break;
            end
            if (!hold_start)
                start = (spurious && (busy || done)) ? 1'($urandom_range(1, 0)) : 1'b0;
            resp = 0;
            if (armed) begin
                if (rd_cnt == 0) begin
                    rd_valid = 1'b1; armed = 0; resp = 1;
                end else begin
                    rd_valid = 1'b0; rd_cnt--;
                end
            end else begin
                rd_valid = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            if (rd_en) begin
                rd_q.push_back(int'(addr));
                armed = 1;
                rd_cnt = rd_lat[addr];
            end
            if (wr_en) begin
                if (!wr_act) begin
                    wr_act = 1; wr_cnt = wr_lat[addr]; wr_addr0 = int'(addr);
                end else if (int'(addr) != wr_addr0) begin
                    obs_wr_unstable++;
                end
                wr_ready = (wr_cnt == 0);
                if (wr_cnt > 0) wr_cnt--;
                if (wr_ready) begin
                    wr_q.push_back(int'(addr));
                    wr_act = 0;
                end
            end else begin
                wr_ready = spurious ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            #1;
            if (reg_ld !== (resp | resp_prev)) obs_ld_bad++;
            if (perm_sel !== resp_prev) obs_ld_bad++;
            resp_prev = resp;
            if ((rd_en && wr_en) || (reg_clr && reg_ld)) obs_excl++;
            if (reg_clr) obs_clr = cyc;
            if (busy) obs_busy++;
            if (!busy && addr != '0) obs_idle_addr++;
            if (done) begin
                obs_done_cnt++;
                obs_done = cyc;
                break;
            end
        end
        if (!hold_start) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, wr_en, addr, reg_clr, reg_ld, perm_sel, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {rd_en, wr_en, addr, reg_clr, reg_ld, perm_sel, busy, done});
        end
        rst = 1'b0;
        rd_valid = 1'b1; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, wr_en, busy, done} !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_start: got %b expected 0", {rd_en, wr_en, busy, done});
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_nominal();
        int lat;
        clear_lat();
        lat = exp_latency();
        run_pass(0, 0, -1);
        checks++;
        if (obs_done - obs_start != lat) begin
            errors++; $display("FAIL nominal_latency: got %0d expected %0d", obs_done - obs_start, lat);
        end
        checks++;
        if (seq_errs(0) != 0) begin
            errors++; $display("FAIL nominal_rd_order: got %0d errors (%0d reads) expected 0", seq_errs(0), rd_q.size());
        end
        checks++;
        if (seq_errs(1) != 0) begin
            errors++; $display("FAIL nominal_wr_order: got %0d errors (%0d writes) expected 0", seq_errs(1), wr_q.size());
        end
        checks++;
        if (obs_clr - obs_start != 1) begin
            errors++; $display("FAIL nominal_clear_cycle: got %0d expected 1", obs_clr - obs_start);
        end
        checks++;
        if (obs_busy != lat - 1) begin
            errors++; $display("FAIL nominal_busy_cycles: got %0d expected %0d", obs_busy, lat - 1);
        end
        checks++;
        if (obs_ld_bad + obs_excl + obs_idle_addr != 0) begin
            errors++; $display("FAIL nominal_protocol: got ld=%0d excl=%0d addr=%0d expected 0", obs_ld_bad, obs_excl, obs_idle_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, rd_en} !== 3'd0) begin
            errors++; $display("FAIL nominal_post_idle: got %b expected 0", {busy, done, rd_en});
        end
    endtask

    task automatic test_read_latency();
        clear_lat();
        rd_lat[5] = 3;
        run_pass(0, 0, -1);
        checks++;
        if (obs_done - obs_start != 2 + 4 * LINES + 3) begin
            errors++; $display("FAIL rdlat_latency: got %0d expected %0d", obs_done - obs_start, 2 + 4 * LINES + 3);
        end
        checks++;
        if (obs_ld_bad != 0) begin
            errors++; $display("FAIL rdlat_reg_ld: got %0d misplaced expected 0", obs_ld_bad);
        end
        checks++;
        if (seq_errs(0) + seq_errs(1) != 0) begin
            errors++; $display("FAIL rdlat_order: got %0d errors expected 0", seq_errs(0) + seq_errs(1));
        end
    endtask

    task automatic test_write_backpressure();
        clear_lat();
        wr_lat[LINES-1] = 4;
        run_pass(0, 0, -1);
        checks++;
        if (obs_done - obs_start != 2 + 4 * LINES + 4) begin
            errors++; $display("FAIL wrbp_latency: got %0d expected %0d", obs_done - obs_start, 2 + 4 * LINES + 4);
        end
        checks++;
        if (obs_wr_unstable != 0) begin
            errors++; $display("FAIL wrbp_addr_stable: got %0d changes expected 0", obs_wr_unstable);
        end
        checks++;
        if (seq_errs(1) != 0) begin
            errors++; $display("FAIL wrbp_wr_order: got %0d errors expected 0", seq_errs(1));
        end
    endtask

    task automatic test_spurious();
        clear_lat();
        run_pass(0, 1, -1);
        checks++;
        if (obs_done - obs_start != 2 + 4 * LINES) begin
            errors++; $display("FAIL spur_latency: got %0d expected %0d", obs_done - obs_start, 2 + 4 * LINES);
        end
        checks++;
        if (seq_errs(0) + seq_errs(1) + obs_ld_bad + obs_excl != 0) begin
            errors++; $display("FAIL spur_protocol: got %0d errors expected 0", seq_errs(0) + seq_errs(1) + obs_ld_bad + obs_excl);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL spur_no_restart: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < LINES; i++) begin
                rd_lat[i] = $urandom_range(3, 0);
                wr_lat[i] = $urandom_range(3, 0);
            end
            lat = exp_latency();
            run_pass(0, 1, -1);
            checks++;
            if (obs_done - obs_start != lat) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", r, obs_done - obs_start, lat);
            end
            checks++;
            if (seq_errs(0) + seq_errs(1) + obs_wr_unstable != 0) begin
                errors++; $display("FAIL rand_order[%0d]: got %0d errors expected 0", r, seq_errs(0) + seq_errs(1) + obs_wr_unstable);
            end
            checks++;
            if (obs_ld_bad + obs_excl + obs_idle_addr != 0 || obs_busy != lat - 1) begin
                errors++; $display("FAIL rand_protocol[%0d]: got ld=%0d excl=%0d busy=%0d expected 0 0 %0d", r, obs_ld_bad, obs_excl, obs_busy, lat - 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        int done_seen = 0;
        clear_lat();
        run_pass(0, 0, 20);
        checks++;
        if (!obs_aborted || obs_snap !== 13'd0) begin
            errors++; $display("FAIL midrst_outputs: got %b (aborted=%0d) expected 0", obs_snap, obs_aborted);
        end
        start = 1'b0; rd_valid = 1'b0; wr_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        checks++;
        if (obs_done_cnt + done_seen != 0) begin
            errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", obs_done_cnt + done_seen);
        end
        run_pass(0, 0, -1);
        checks++;
        if (rd_q.size() == 0 || rd_q[0] != 0 || seq_errs(0) != 0) begin
            errors++; $display("FAIL midrst_restart_addr: got %0d errors expected 0", seq_errs(0));
        end
        checks++;
        if (obs_done - obs_start != 2 + 4 * LINES) begin
            errors++; $display("FAIL midrst_latency: got %0d expected %0d", obs_done - obs_start, 2 + 4 * LINES);
        end
    endtask

    task automatic test_back_to_back();
        int prev_done;
        clear_lat();
        run_pass(1, 0, -1);
        prev_done = obs_done;
        checks++;
        if (obs_done - obs_start != 2 + 4 * LINES) begin
            errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", obs_done - obs_start, 2 + 4 * LINES);
        end
        run_pass(1, 0, -1);
        start = 1'b0;
        checks++;
        if (obs_clr - prev_done != 2) begin
            errors++; $display("FAIL b2b_clear_gap: got %0d expected 2", obs_clr - prev_done);
        end
        checks++;
        // One IDLE cycle, one CLEAR cycle, 4 per line, then the DONE cycle.
        if (obs_done - prev_done != 3 + 4 * LINES) begin
            errors++; $display("FAIL b2b_done_period: got %0d expected %0d", obs_done - prev_done, 3 + 4 * LINES);
        end
        checks++;
        if (seq_errs(0) + seq_errs(1) != 0) begin
            errors++; $display("FAIL b2b_order: got %0d errors expected 0", seq_errs(0) + seq_errs(1));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_read_latency();
        test_write_backpressure();
        test_spurious();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
